// File: rtl/nrdiv_fsm_pkg.sv
// Shared arithmetic package for the small sequential arithmetic blocks (divider and Booth
// multiplier FSMs).
// Contents:
//   state_e   - common three-state control encoding (idle / iterate / finalise)
//   cnt_width - width of an iteration counter able to hold 0..dw
package nrdiv_fsm_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/nrdiv_fsm_if.sv
// Handshake/operand bundle shared by the divider and its driver.
// Signals:
//   en        - start request (driver -> divider)
//   dividend  - signed dividend (driver -> divider)
//   divisor   - signed divisor (driver -> divider)
//   done      - result valid (divider -> driver)
//   quotient  - signed quotient (divider -> driver)
//   remainder - signed remainder (divider -> driver)
//   div_zero  - last operation had a zero divisor (divider -> driver)
interface nrdiv_fsm_if #(
  parameter int unsigned DATAWIDTH = 8
);

  logic                 en;
  logic [DATAWIDTH-1:0] dividend;
  logic [DATAWIDTH-1:0] divisor;
  logic                 done;
  logic [DATAWIDTH-1:0] quotient;
  logic [DATAWIDTH-1:0] remainder;
  logic                 div_zero;

  modport master (
    output en, dividend, divisor,
    input  done, quotient, remainder, div_zero
  );

  modport slave (
    input  en, dividend, divisor,
    output done, quotient, remainder, div_zero
  );

endinterface

// File: rtl/nrdiv_fsm_twos_abs.sv
// Conditional two's-complement negate: y_o = neg_i ? -a_i : a_i.
// Used with neg_i = sign bit to form a magnitude, and with neg_i = a sign flag to re-apply
// a sign to an unsigned magnitude.
// Ports:
//   a_i   - input value
//   neg_i - negate when high
//   y_o   - result, same width as a_i
module nrdiv_fsm_twos_abs #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic             neg_i,
  output logic [Width-1:0] y_o
);

  always_comb begin
    y_o = neg_i ? (~a_i + Width'(1)) : a_i;
  end

endmodule

// File: rtl/nrdiv_fsm.sv
// Sequential signed non-restoring divider, one quotient bit per clock.
// Quotient truncates toward zero, remainder takes the sign of the dividend. Start is accepted
// only in idle; done rises DATAWIDTH+1 edges after the start edge and results hold until the
// next FIX. A zero divisor still runs full latency and yields quotient=-1, remainder=dividend.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous reset, active high
//   bus - nrdiv_fsm_if slave modport (en/dividend/divisor in, done/quotient/remainder/div_zero out)
module nrdiv_fsm
  import nrdiv_fsm_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  nrdiv_fsm_if.slave  bus
);

  localparam int unsigned DW   = DATAWIDTH;
  localparam int unsigned CntW = cnt_width(DATAWIDTH);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW:0]     p_q, p_d;      // signed partial remainder, bit DW is the sign
  logic [DW-1:0]   q_q, q_d;      // dividend magnitude shifting out, quotient bits shifting in
  logic [DW-1:0]   d_q, d_d;      // divisor magnitude
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic            dz_q, dz_d;
  logic            done_q, done_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic            dzo_q, dzo_d;

  // Two conditional negators shared between operand capture (idle) and sign fix-up (FIX).
  logic [DW-1:0] abs0_in, abs0_out, abs1_in, abs1_out;
  logic          abs0_neg, abs1_neg;
  logic [DW:0]   p_fix;

  always_comb begin
    p_fix = p_q[DW] ? (p_q + {1'b0, d_q}) : p_q;
  end

  always_comb begin
    if (state_q == StFix) begin
      abs0_in  = q_q;
      abs0_neg = neg_a_q ^ neg_b_q;
      abs1_in  = p_fix[DW-1:0];
      abs1_neg = neg_a_q;
    end else begin
      abs0_in  = bus.dividend;
      abs0_neg = bus.dividend[DW-1];
      abs1_in  = bus.divisor;
      abs1_neg = bus.divisor[DW-1];
    end
  end

  nrdiv_fsm_twos_abs #(
    .Width (DW)
  ) u_abs0 (
    .a_i   (abs0_in),
    .neg_i (abs0_neg),
    .y_o   (abs0_out)
  );

  nrdiv_fsm_twos_abs #(
    .Width (DW)
  ) u_abs1 (
    .a_i   (abs1_in),
    .neg_i (abs1_neg),
    .y_o   (abs1_out)
  );

  // One non-restoring step. |divisor| <= 2^(DW-1) keeps every intermediate within DW+1 bits.
  logic [DW:0]   p_sh, p_step;
  logic [DW-1:0] q_sh;

  always_comb begin
    p_sh   = {p_q[DW-1:0], q_q[DW-1]};
    p_step = p_q[DW] ? (p_sh + {1'b0, d_q}) : (p_sh - {1'b0, d_q});
    q_sh   = {q_q[DW-2:0], ~p_step[DW]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d    = dz_q;
    done_d  = done_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;

    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          q_d     = abs0_out;
          d_d     = abs1_out;
          neg_a_d = bus.dividend[DW-1];
          neg_b_d = bus.divisor[DW-1];
          dz_d    = (bus.divisor == '0);
          cnt_d   = '0;
          p_d     = '0;
          done_d  = 1'b0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        p_d   = p_step;
        q_d   = q_sh;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DW - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // With a zero divisor P accumulates |dividend| untouched, so the signed remainder
        // path already yields the dividend; only the quotient needs forcing.
        p_d     = p_fix;
        quo_d   = dz_q ? '1 : abs0_out;
        rem_d   = abs1_out;
        dzo_d   = dz_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
    end
  end

  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dzo_q;

endmodule

// File: tb/tb_nrdiv_fsm.sv
module tb_nrdiv_fsm;

  localparam int unsigned DW = 10;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  nrdiv_fsm_if #(.DATAWIDTH(DW)) bus ();

  nrdiv_fsm #(
    .DATAWIDTH (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands, let the next edge accept them, then scramble operands.
  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit hold_en);
    bus.en       = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.en       = hold_en;
    bus.dividend = DW'($urandom);
    bus.divisor  = DW'($urandom);
  endtask

  // Count edges after the start edge until done; a timeout shows up as a latency mismatch.
  task automatic wait_done(input string tag);
    int lat  = 0;
    bit seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      seen = bus.done;
    end
    check_eq({tag, "/latency"}, lat, 11);
  endtask

  task automatic check_res(input string tag, input logic [DW-1:0] eq, input logic [DW-1:0] er,
                           input logic edz);
    check_eq({tag, "/quotient"}, bus.quotient, eq);
    check_eq({tag, "/remainder"}, bus.remainder, er);
    check_eq({tag, "/div_zero"}, bus.div_zero, edz);
  endtask

  function automatic logic [DW-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 10'h200;
      1:       return 10'h1FF;
      2:       return 10'h000;
      3:       return 10'h3FF;
      4:       return 10'h201;
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    logic [DW-1:0] a, b, eq, er;
    logic          edz;
    int            ai, bi;
    bit            saw;

    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_eq("reset/done", bus.done, 1'b0);
    check_res("reset", '0, '0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 100 / 7 with a one-cycle en pulse.
    start_op(10'd100, 10'd7, 1'b0);
    wait_done("100div7");
    check_res("100div7", 10'd14, 10'd2, 1'b0);

    // Reset in the middle of CALC aborts; no done follows.
    start_op(10'd200, 10'd9, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("abort/done", bus.done, 1'b0);
    check_res("abort", '0, '0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      saw = saw | bus.done;
    end
    check_eq("abort/no_done", saw, 1'b0);

    // -512 / 3, then 7 / -2.
    start_op(10'h200, 10'd3, 1'b0);
    wait_done("m512div3");
    check_res("m512div3", 10'(-170), 10'(-2), 1'b0);
    start_op(10'd7, 10'(-2), 1'b0);
    wait_done("7divm2");
    check_res("7divm2", 10'(-3), 10'd1, 1'b0);

    // Divide by zero, then a normal op; results hold across the start edge.
    start_op(10'd37, 10'd0, 1'b0);
    wait_done("37div0");
    check_res("37div0", 10'h3FF, 10'd37, 1'b1);
    start_op(10'd5, 10'd5, 1'b0);
    check_eq("hold/done_clears", bus.done, 1'b0);
    check_eq("hold/quotient", bus.quotient, 10'h3FF);
    check_eq("hold/div_zero", bus.div_zero, 1'b1);
    wait_done("5div5");
    check_res("5div5", 10'd1, 10'd0, 1'b0);

    // Overflow case with en held high, then back-to-back 9 / 4.
    start_op(10'h200, 10'h3FF, 1'b1);
    bus.dividend = 10'd9;
    bus.divisor  = 10'd4;
    wait_done("m512divm1");
    check_res("m512divm1", 10'h200, 10'd0, 1'b0);
    @(posedge clk);
    #1;
    check_eq("b2b/done_low", bus.done, 1'b0);
    bus.en = 1'b0;
    wait_done("9div4");
    check_res("9div4", 10'd2, 10'd1, 1'b0);

    // Randomised sweep against the language's signed / and %.
    for (int i = 0; i < 1000; i++) begin
      a  = pick_operand();
      b  = pick_operand();
      ai = $signed(a);
      bi = $signed(b);
      if (bi == 0) begin
        eq  = '1;
        er  = a;
        edz = 1'b1;
      end else begin
        eq  = DW'(ai / bi);
        er  = DW'(ai % bi);
        edz = 1'b0;
      end
      start_op(a, b, 1'b0);
      wait_done("rnd");
      check_res("rnd", eq, er, edz);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
